wb_master_port: RTL and testbench

- Wishbone B4 pipelined single-transfer initiator (master). It issues one read or write at a time on behalf of a simple request/response client, such as the CPU load/store unit or a debug bridge.
- Drives the slave-side CSR decoders (e.g. the system/UART/video CSR bank) and any other pipelined WB responder.
- Handles STALL, ACK, ERR and RTY, retries on RTY, and returns read data plus an error flag to the client.

---
 rtl/wb_master_port.sv | 158 +++++++++++++++
 tb/tb_wb_master_port.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_master_port.sv
// Wishbone B4 pipelined single-transfer initiator with RTY reissue.
// Optional watchdog: define WB_MASTER_TIMEOUT_EN.
module wb_master_port #(
  parameter int ADR_WIDTH      = 30,
  parameter int MAX_RETRY      = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  input  logic                 req_we_i,
  input  logic [ADR_WIDTH-1:0] req_adr_i,
  input  logic [3:0]           req_sel_i,
  input  logic [31:0]          req_dat_i,
  output logic                 req_ready_o,
  output logic                 rsp_valid_o,
  output logic                 rsp_err_o,
  output logic [31:0]          rsp_dat_o,
  output logic                 wb_cyc_o,
  output logic                 wb_stb_o,
  output logic                 wb_we_o,
  output logic [ADR_WIDTH-1:0] wb_adr_o,
  output logic [3:0]           wb_sel_o,
  output logic [31:0]          wb_dat_o,
  input  logic                 wb_ack_i,
  input  logic                 wb_err_i,
  input  logic                 wb_rty_i,
  input  logic                 wb_stall_i,
  input  logic [31:0]          wb_dat_i
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  logic [2:0]    state;
  logic [RW-1:0] retry_cnt;
  logic          live;
  logic          term;
  logic          retry_ok;

  // A termination only counts once the strobe has been taken.
  assign live     = (state == S_WAIT) ||
                    ((state == S_REQ) && !wb_stall_i);
  assign term     = wb_ack_i | wb_err_i | wb_rty_i;
  assign retry_ok = retry_cnt < RW'(MAX_RETRY);

`ifdef WB_MASTER_TIMEOUT_EN
  localparam logic [2:0] S_TOUT = 3'd4;
  localparam int TW_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TW = (TW_RAW < 8)  ? 8 :
                      (TW_RAW > 16) ? 16 : TW_RAW;

  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;

  assign tmo_hit = tmo_cnt == TW'(TIMEOUT_CYCLES - 1);
`else
  // Watchdog is compiled out in this build.
  localparam int unused_tmo = TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      retry_cnt   <= '0;
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_dat_o   <= '0;
      wb_cyc_o    <= 1'b0;
      wb_stb_o    <= 1'b0;
      wb_we_o     <= 1'b0;
      wb_adr_o    <= '0;
      wb_sel_o    <= '0;
      wb_dat_o    <= '0;
`ifdef WB_MASTER_TIMEOUT_EN
      tmo_cnt     <= '0;
`endif
    end else begin
      rsp_valid_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_i) begin
            wb_we_o     <= req_we_i;
            wb_adr_o    <= req_adr_i;
            wb_sel_o    <= req_sel_i;
            wb_dat_o    <= req_dat_i;
            wb_cyc_o    <= 1'b1;
            wb_stb_o    <= 1'b1;
            req_ready_o <= 1'b0;
            retry_cnt   <= '0;
            state       <= S_REQ;
`ifdef WB_MASTER_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
          end
        end
        S_REQ, S_WAIT: begin
          if (live) begin
            wb_stb_o <= 1'b0;
            state    <= S_WAIT;
          end
          if (live && term) begin
            wb_stb_o <= 1'b0;
            wb_cyc_o <= 1'b0;
            if (wb_rty_i && !wb_err_i && retry_ok) begin
              retry_cnt <= retry_cnt + 1'b1;
              state     <= S_GAP;
            end else begin
              rsp_valid_o <= 1'b1;
              req_ready_o <= 1'b1;
              state       <= S_IDLE;
              rsp_err_o   <= wb_err_i | wb_rty_i;
              if (!wb_err_i && !wb_rty_i && !wb_we_o)
                rsp_dat_o <= wb_dat_i;
            end
          end
`ifdef WB_MASTER_TIMEOUT_EN
          else if (tmo_hit) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            state    <= S_TOUT;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        S_GAP: begin
          wb_cyc_o <= 1'b1;
          wb_stb_o <= 1'b1;
          state    <= S_REQ;
`ifdef WB_MASTER_TIMEOUT_EN
          tmo_cnt  <= '0;
`endif
        end
`ifdef WB_MASTER_TIMEOUT_EN
        S_TOUT: begin
          rsp_valid_o <= 1'b1;
          rsp_err_o   <= 1'b1;
          req_ready_o <= 1'b1;
          state       <= S_IDLE;
        end
`endif
        default: begin
          wb_cyc_o    <= 1'b0;
          wb_stb_o    <= 1'b0;
          req_ready_o <= 1'b1;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_master_port.sv
// Bench for wb_master_port: behavioural WB slave plus response scoreboard.
// Timeout case runs only when WB_MASTER_TIMEOUT_EN is defined.
module tb_wb_master_port;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_i;
  logic        req_we_i;
  logic [29:0] req_adr_i;
  logic [3:0]  req_sel_i;
  logic [31:0] req_dat_i;
  logic        req_ready_o;
  logic        rsp_valid_o;
  logic        rsp_err_o;
  logic [31:0] rsp_dat_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [29:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic        wb_rty_i;
  logic        wb_stall_i;
  logic [31:0] wb_dat_i;

  wb_master_port #(
    .ADR_WIDTH(30),
    .MAX_RETRY(3),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .req_i(req_i),
    .req_we_i(req_we_i),
    .req_adr_i(req_adr_i),
    .req_sel_i(req_sel_i),
    .req_dat_i(req_dat_i),
    .req_ready_o(req_ready_o),
    .rsp_valid_o(rsp_valid_o),
    .rsp_err_o(rsp_err_o),
    .rsp_dat_o(rsp_dat_o),
    .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o),
    .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o),
    .wb_sel_o(wb_sel_o),
    .wb_dat_o(wb_dat_o),
    .wb_ack_i(wb_ack_i),
    .wb_err_i(wb_err_i),
    .wb_rty_i(wb_rty_i),
    .wb_stall_i(wb_stall_i),
    .wb_dat_i(wb_dat_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [31:0] dat;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_cnt  = 0;
  int acc_cyc  = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Slave: two-cycle registered response, optional stall/rty/err/silence.
  logic [31:0] mem [0:31];
  int          delay      = 0;
  int          stall_left = 0;
  int          rty_left   = 0;
  bit          err_mode   = 0;
  bit          silent     = 0;
  logic        s_we;
  logic [29:0] s_adr;
  logic [31:0] s_dat;
  int          n_stb      = 0;
  int          n_term     = 0;

  initial begin
    wb_ack_i   = 1'b0;
    wb_err_i   = 1'b0;
    wb_rty_i   = 1'b0;
    wb_stall_i = 1'b0;
    wb_dat_i   = '0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    mem[11] = 32'h00F00140;
  end

  always @(negedge clk) begin
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_rty_i = 1'b0;
    if (rst_i) begin
      delay      = 0;
      wb_stall_i = 1'b0;
    end else begin
      if (delay > 0) begin
        delay--;
        if (delay == 0) begin
          n_term++;
          if (rty_left > 0) begin
            wb_rty_i = 1'b1;
            rty_left--;
          end else if (err_mode) begin
            wb_err_i = 1'b1;
            wb_ack_i = 1'b1;
            wb_dat_i = 32'hDEADBEEF;
          end else begin
            wb_ack_i = 1'b1;
            if (s_we) mem[s_adr[4:0]] = s_dat;
            else      wb_dat_i = mem[s_adr[4:0]];
          end
        end
      end
      if (wb_cyc_o && wb_stb_o && stall_left > 0) begin
        wb_stall_i = 1'b1;
        stall_left--;
      end else begin
        wb_stall_i = 1'b0;
        if (wb_cyc_o && wb_stb_o) begin
          n_stb++;
          s_we  = wb_we_o;
          s_adr = wb_adr_o;
          s_dat = wb_dat_o;
          if (!silent) delay = 2;
        end
      end
    end
  end

  // Monitor: per-transaction timing stats and scoreboard pop.
  int          first_stb_rel, stb_fall_rel, cyc_fall_rel, rsp_rel;
  int          stb_cycles, cyc_rises, gap_cycles, unstable, n_rsp;
  int          last_rsp_abs = 0;
  logic        cyc_prev = 1'b0;
  logic        stb_prev = 1'b0;
  logic [29:0] cap_adr;
  logic [31:0] cap_dat;

  task automatic clr_stats();
    first_stb_rel = -1;
    stb_fall_rel  = -1;
    cyc_fall_rel  = -1;
    rsp_rel       = -1;
    stb_cycles    = 0;
    cyc_rises     = 0;
    gap_cycles    = 0;
    unstable      = 0;
    n_rsp         = 0;
    n_stb         = 0;
    n_term        = 0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_i) begin
      if (wb_cyc_o && !cyc_prev) cyc_rises++;
      if (wb_stb_o) begin
        stb_cycles++;
        if (first_stb_rel < 0) begin
          first_stb_rel = cyc_cnt - acc_cyc;
          cap_adr = wb_adr_o;
          cap_dat = wb_dat_o;
        end else if (wb_adr_o !== cap_adr || wb_dat_o !== cap_dat) begin
          unstable++;
        end
      end
      if (stb_prev && !wb_stb_o && stb_fall_rel < 0)
        stb_fall_rel = cyc_cnt - acc_cyc;
      if (cyc_prev && !wb_cyc_o && cyc_fall_rel < 0)
        cyc_fall_rel = cyc_cnt - acc_cyc;
      if (!wb_cyc_o && first_stb_rel >= 0 && !rsp_valid_o && sb.size() > 0)
        gap_cycles++;
      if (rsp_valid_o) begin
        n_rsp++;
        rsp_rel = cyc_cnt - acc_cyc;
        last_rsp_abs = cyc_cnt;
        if (sb.size() == 0) begin
          check("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("rsp_err", {31'd0, rsp_err_o}, {31'd0, e.err});
          check("rsp_dat", rsp_dat_o, e.dat);
        end
      end
      cyc_prev = wb_cyc_o;
      stb_prev = wb_stb_o;
    end else begin
      cyc_prev = 1'b0;
      stb_prev = 1'b0;
    end
  end

  task automatic send(input logic we, input logic [29:0] adr,
                      input logic [31:0] dat, input logic exp_err,
                      input logic [31:0] exp_dat);
    int i;
    i = 0;
    req_i     = 1'b1;
    req_we_i  = we;
    req_adr_i = adr;
    req_sel_i = 4'hF;
    req_dat_i = dat;
    while (!req_ready_o && i < 50) begin
      @(negedge clk);
      i++;
    end
    if (!req_ready_o) begin
      check("accept", 32'd0, 32'd1);
      req_i = 1'b0;
      return;
    end
    acc_cyc = cyc_cnt;
    sb.push_back('{exp_err, exp_dat});
    @(negedge clk);
    req_i = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int i;
    i = 0;
    while (sb.size() > 0 && i < lim) begin
      @(negedge clk);
      i++;
    end
    check("wait_done", sb.size(), 32'd0);
    sb.delete();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "simulation hung");
  end

  int acc_b;

  initial begin
    rst_i     = 1'b1;
    req_i     = 1'b0;
    req_we_i  = 1'b0;
    req_adr_i = '0;
    req_sel_i = '0;
    req_dat_i = '0;
    clr_stats();
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);

    check("rst_ready", {31'd0, req_ready_o}, 32'd1);
    check("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
    check("rst_stb", {31'd0, wb_stb_o}, 32'd0);
    check("rst_valid", {31'd0, rsp_valid_o}, 32'd0);
    check("rst_dat", rsp_dat_o, 32'd0);
    check("rst_adr", {2'd0, wb_adr_o}, 32'd0);

    // Plain write: reference latency.
    clr_stats();
    send(1'b1, 30'd9, 32'h00123456, 1'b0, 32'h0);
    wait_idle(30);
    check("wr_stb_rel", first_stb_rel, 32'd1);
    check("wr_stb_fall", stb_fall_rel, 32'd2);
    check("wr_rsp_rel", rsp_rel, 32'd4);
    check("wr_mem", mem[9], 32'h00123456);
    check("wr_sel", {28'd0, wb_sel_o}, 32'hF);

    // Read followed immediately by a second read.
    clr_stats();
    send(1'b0, 30'd11, 32'h0, 1'b0, 32'h00F00140);
    send(1'b0, 30'd9, 32'h0, 1'b0, 32'h00123456);
    acc_b = acc_cyc;
    check("b2b_accept", acc_b, last_rsp_abs);
    wait_idle(30);

    // Stall for three cycles after the strobe.
    clr_stats();
    stall_left = 3;
    send(1'b1, 30'd3, 32'hAAAA5555, 1'b0, 32'h00123456);
    wait_idle(30);
    check("stall_stb_cycles", stb_cycles, 32'd4);
    check("stall_stable", unstable, 32'd0);
    check("stall_terms", n_term, 32'd1);
    check("stall_mem", mem[3], 32'hAAAA5555);

    // Two RTYs then ACK.
    clr_stats();
    rty_left = 2;
    send(1'b0, 30'd11, 32'h0, 1'b0, 32'h00F00140);
    wait_idle(40);
    check("rty2_strobes", n_stb, 32'd3);
    check("rty2_cyc_rises", cyc_rises, 32'd3);
    check("rty2_gap_cycles", gap_cycles, 32'd2);

    // Four RTYs exhaust the retry budget.
    clr_stats();
    rty_left = 4;
    send(1'b0, 30'd9, 32'h0, 1'b1, 32'h00F00140);
    wait_idle(50);
    check("rty4_strobes", n_stb, 32'd4);
    rty_left = 0;

    // ERR and ACK together: error wins, data held.
    clr_stats();
    err_mode = 1;
    send(1'b0, 30'd9, 32'h0, 1'b1, 32'h00F00140);
    wait_idle(30);
    err_mode = 0;
    check("errack_terms", n_term, 32'd1);

`ifdef WB_MASTER_TIMEOUT_EN
    clr_stats();
    silent = 1;
    send(1'b0, 30'd4, 32'h0, 1'b1, 32'h00F00140);
    wait_idle(40);
    silent = 0;
    check("tmo_cyc_fall", cyc_fall_rel, 32'd17);
    check("tmo_rsp_rel", rsp_rel, 32'd18);
`endif

    // Reset in the middle of WAIT.
    clr_stats();
    silent = 1;
    send(1'b0, 30'd5, 32'h0, 1'b0, 32'h0);
    repeat (3) @(negedge clk);
    #2;
    rst_i = 1'b1;
    #1;
    check("arst_cyc", {31'd0, wb_cyc_o}, 32'd0);
    check("arst_stb", {31'd0, wb_stb_o}, 32'd0);
    check("arst_ready", {31'd0, req_ready_o}, 32'd1);
    sb.delete();
    @(negedge clk);
    rst_i = 1'b0;
    silent = 0;
    clr_stats();
    repeat (6) @(negedge clk);
    check("arst_no_rsp", n_rsp, 32'd0);
    check("arst_dat", rsp_dat_o, 32'd0);

    // Normal traffic resumes after reset.
    clr_stats();
    send(1'b0, 30'd3, 32'h0, 1'b0, 32'hAAAA5555);
    wait_idle(30);
    check("post_rsp_rel", rsp_rel, 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
